// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/shift/add ops, plus an optional iterative
// multiply/divide unit (shift-add / restoring divide) enabled by ALU_MULDIV_EN.
module seq_alu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_ctrl,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0]   shamt;
  logic            fire;
  logic [XLEN-1:0] sc_res;
  logic [XLEN-1:0] result_q, res_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, ov_d;

  assign shamt = b[SW-1:0];
  assign fire  = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
  logic is_multi;
`endif

  always_comb begin
    sc_res = '0;
`ifdef ALU_MULDIV_EN
    is_multi = 1'b0;
`endif
    case (alu_ctrl)
      4'b0000: sc_res = a & b;
      4'b0001: sc_res = a | b;
      4'b0010: sc_res = a + b;
      4'b0011: sc_res = a ^ b;
      4'b0100: sc_res = a << shamt;
      4'b0101: sc_res = a >> shamt;
      4'b0110: sc_res = a - b;
      4'b1001: sc_res = $unsigned($signed(a) >>> shamt);
`ifdef ALU_MULDIV_EN
      4'b1010, 4'b1011: is_multi = 1'b1;
      // Divide by zero short-circuits to a single-cycle answer.
      4'b1100: if (b == '0) sc_res = '1; else is_multi = 1'b1;
      4'b1101: if (b == '0) sc_res = a;  else is_multi = 1'b1;
`endif
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int CW = SW + 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic            mul_q, mul_d;
  logic            hi_q, hi_d;
  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
  logic [XLEN-1:0] acc_step, lo_step;

  assign in_ready = (state_q == IDLE);

  // acc holds the product high half / partial remainder; lo holds the
  // multiplier / dividend being consumed and receives product low bits / quotient.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = {acc_q, lo_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    acc_step = acc_q;
    lo_step  = lo_q;
    if (mul_q) begin
      acc_step = mul_sum[XLEN:1];
      lo_step  = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (!rem_diff[XLEN]) begin
      acc_step = rem_diff[XLEN-1:0];
      lo_step  = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = rem_sh[XLEN-1:0];
      lo_step  = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    mul_d   = mul_q;
    hi_d    = hi_q;
    res_d   = result_q;
    zero_d  = zero_q;
    ov_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (is_multi) begin
            state_d = BUSY;
            cnt_d   = CW'(XLEN);
            acc_d   = '0;
            mul_d   = (alu_ctrl[3:1] == 3'b101);
            hi_d    = alu_ctrl[0];
            opb_d   = mul_d ? a : b;
            lo_d    = mul_d ? b : a;
          end else begin
            res_d  = sc_res;
            zero_d = (sc_res == '0);
            ov_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        acc_d = acc_step;
        lo_d  = lo_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          res_d   = hi_q ? acc_step : lo_step;
          zero_d  = ((hi_q ? acc_step : lo_step) == '0);
          ov_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      mul_q   <= 1'b0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      mul_q   <= mul_d;
      hi_q    <= hi_d;
    end
  end
`else
  assign in_ready = 1'b1;

  always_comb begin
    res_d  = result_q;
    zero_d = zero_q;
    ov_d   = 1'b0;
    if (fire) begin
      res_d  = sc_res;
      zero_d = (sc_res == '0);
      ov_d   = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= res_d;
      zero_q      <= zero_d;
      out_valid_q <= ov_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes model results with due cycle,
// monitor pops on out_valid. Follows ALU_MULDIV_EN the same way as the design.
module tb_seq_alu;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic [3:0]      alu_ctrl = '0;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            zero;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_ctrl(alu_ctrl),
    .out_valid(out_valid), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          busy_until = 0;
  logic [63:0] last_res = '0;
  int          checks = 0;
  int          errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    logic [127:0] xx, yy, p;
    int sh;
    sh = int'(y % 64);
    xx = {64'd0, x};
    yy = {64'd0, y};
    p  = '0;
    case (op)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return x ^ y;
      4'd4:  return x << sh;
      4'd5:  return x >> sh;
      4'd6:  return x - y;
      4'd9: begin
        p = {{64{x[63]}}, x} >> sh;
        return p[63:0];
      end
`ifdef ALU_MULDIV_EN
      4'd10: begin p = xx * yy; return p[63:0]; end
      4'd11: begin p = xx * yy; return p[127:64]; end
      4'd12: return (y == 0) ? {64{1'b1}} : x / y;
      4'd13: return (y == 0) ? x : x % y;
`endif
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit ref_multi(input logic [3:0] op, input logic [63:0] y);
`ifdef ALU_MULDIV_EN
    return (op == 4'd10) || (op == 4'd11) || ((op == 4'd12 || op == 4'd13) && y != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive_now(input logic v, input logic [3:0] op, input logic [63:0] aa,
                           input logic [63:0] bb, output bit accepted);
    exp_t e;
    bit   idle;
    in_valid = v;
    alu_ctrl = op;
    a        = aa;
    b        = bb;
    idle     = (cyc >= busy_until);
    chk("in_ready", {63'd0, in_ready}, {63'd0, idle});
    accepted = v && idle;
    if (accepted) begin
      e.res = ref_res(op, aa, bb);
      e.due = cyc + 1 + (ref_multi(op, bb) ? XLEN : 0);
      if (ref_multi(op, bb)) busy_until = cyc + 1 + XLEN;
      sb_q.push_back(e);
    end
  endtask

  task automatic drive_cycle(input logic v, input logic [3:0] op, input logic [63:0] aa,
                             input logic [63:0] bb, output bit accepted);
    @(negedge clk);
    drive_now(v, op, aa, bb, accepted);
  endtask

  task automatic send(input logic [3:0] op, input logic [63:0] aa, input logic [63:0] bb);
    bit acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) drive_cycle(1'b1, op, aa, bb, acc);
    chk("send_accepted", {63'd0, acc}, 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 4'd0, 64'd0, 64'd0, acc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("zero", {63'd0, zero}, {63'd0, e.res == 0});
          chk("latency", 64'(cyc), 64'(e.due));
          last_res = e.res;
        end
      end else begin
        chk("hold_result", result, last_res);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    logic [3:0]  op;
    logic [63:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_result", result, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    drive_now(1'b1, 4'b0010, 64'd10, 64'd20, acc);
    chk("accept_after_reset", {63'd0, acc}, 64'd1);
    drive_cycle(1'b1, 4'b0110, 64'd20, 64'd10, acc);
    chk("back_to_back_accept", {63'd0, acc}, 64'd1);
    send(4'b1001, 64'hFFFF_FFFF_FFFF_FFF8, 64'd65);
    send(4'b0100, 64'h1, 64'd127);
    send(4'b0110, 64'd5, 64'd5);
    send(4'b0111, 64'd3, 64'd4);
    send(4'b1010, 64'd7, 64'd6);
    send(4'b1011, 64'h8000_0000_0000_0000, 64'd4);
    send(4'b1100, 64'd100, 64'd7);
    send(4'b1101, 64'd100, 64'd7);
    send(4'b1100, 64'd5, 64'd0);
    send(4'b1101, 64'd5, 64'd0);
    send(4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    send(4'b1011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);

    // Abort a divide mid-flight; nothing may come out for it.
    send(4'b1100, 64'd1000, 64'd7);
    idle_cycles(10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midop_rst_result", result, 64'd0);
    chk("midop_rst_zero", {63'd0, zero}, 64'd1);
    chk("midop_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midop_rst_in_ready", {63'd0, in_ready}, 64'd1);
    sb_q.delete();
    busy_until = 0;
    last_res   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_now(1'b1, 4'b0010, 64'd1, 64'd1, acc);
    chk("accept_after_midop_rst", {63'd0, acc}, 64'd1);

    for (int i = 0; i < 1500; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       rb = 64'd0;
        1:       rb = 64'($urandom_range(0, 130));
        2:       rb = ra;
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 9) == 0) ra = 64'd0;
      drive_cycle($urandom_range(0, 3) != 0, op, ra, rb, acc);
    end

    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clk);
    chk("drain_pending", 64'(sb_q.size()), 64'd0);
    idle_cycles(3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter XLEN, default 64: datapath width; legal values 32 and 64.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: request present on a, b, alu_ctrl.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a request this cycle.
REQ-006 SHALL have port a, input, XLEN bits: operand 1.
REQ-007 SHALL have port b, input, XLEN bits: operand 2, or the shift amount for shift ops.
REQ-008 SHALL have port alu_ctrl, input, 4 bits: operation code.
REQ-009 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new result.
REQ-010 SHALL have port result, output, XLEN bits: registered result.
REQ-011 SHALL have port zero, output, 1 bit: registered flag equal to (result == 0).

Function
REQ-012 SHALL accept a request on a rising edge where in_valid && in_ready; all inputs are sampled only on that edge.
REQ-013 SHALL decode the single-cycle operation codes as follows: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 1001 SRA.
REQ-014 SHALL decode the multi-cycle operation codes as follows: 1010 MUL (low XLEN bits of the product), 1011 MULHU (high XLEN bits of the unsigned product), 1100 DIVU, 1101 REMU.
REQ-015 SHALL compute ADD and SUB modulo 2^XLEN; overflow is ignored and not flagged.
REQ-016 SHALL take the shift amount from b[log2(XLEN)-1:0] and ignore the upper bits of b; SRA SHALL replicate a[XLEN-1].
REQ-017 SHALL complete a single-cycle op accepted at edge N with result, zero and out_valid=1 during the cycle after N; in_ready SHALL stay 1, giving one op per cycle back to back.
REQ-018 SHALL implement the FSM states IDLE and BUSY, with in_ready = (state == IDLE).
REQ-019 SHALL, when a multi-cycle op is accepted in IDLE, enter BUSY and load an iteration counter with XLEN.
REQ-020 SHALL perform one shift-add (MUL/MULHU) or restoring-divide (DIVU/REMU) step per BUSY cycle and decrement the counter each cycle.
REQ-021 SHALL, on the BUSY edge where the counter reaches 0, register result and zero, pulse out_valid the following cycle, and return to IDLE; total latency is XLEN+1 cycles from acceptance.
REQ-022 SHALL treat a DIVU/REMU request with b == 0 as single-cycle: DIVU returns all ones and REMU returns a.
REQ-023 SHALL treat any undefined alu_ctrl value as single-cycle, with result = 0 and zero = 1.
REQ-024 SHALL hold result and zero stable between out_valid pulses.
REQ-025 SHALL assert out_valid for exactly one cycle per accepted request, with no backpressure on the output.
REQ-026 SHALL ignore in_valid while in BUSY, with no queuing and no error.

Reset
REQ-027 SHALL, while rst = 1, asynchronously force state = IDLE, counter = 0, result = 0, zero = 1, out_valid = 0 and in_ready = 1.
REQ-028 SHALL, on reset assertion during BUSY, abort and discard the operation, producing no out_valid pulse for it.
REQ-029 SHALL accept a request on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, when macro ALU_MULDIV_EN is defined, include the multiply/divide datapath, the BUSY state and the counter, with behaviour as in REQ-014 to REQ-022.
REQ-031 SHALL, when ALU_MULDIV_EN is not defined, treat codes 1010-1101 as undefined per REQ-023, omit BUSY, and tie in_ready to 1 outside reset.

Verification
REQ-032 SHALL verify back-to-back ADD then SUB: ADD a=10, b=20, followed by SUB a=20, b=10 on the next cycle -> result 30 on cycle 1, then 10 on cycle 2, with out_valid high both cycles and zero = 0.
REQ-033 SHALL verify shift-amount masking: SRA with XLEN=64, a=0xFFFF_FFFF_FFFF_FFF8, b=65 -> result 0xFFFF_FFFF_FFFF_FFFC, since the effective shift is 1.
REQ-034 SHALL verify MUL latency: MUL a=7, b=6 -> in_ready = 0 for 64 cycles, out_valid at acceptance+65 cycles, result 42.
REQ-035 SHALL verify MULHU, DIVU and REMU: MULHU a=2^63, b=4 -> 2; DIVU a=100, b=7 -> 14; REMU a=100, b=7 -> 2.
REQ-036 SHALL verify divide by zero: DIVU a=5, b=0 -> all ones after 1 cycle; REMU a=5, b=0 -> 5 after 1 cycle.
REQ-037 SHALL verify reset mid-operation: pulse rst 10 cycles into a DIVU -> no out_valid, result 0, zero 1, and a following ADD 1+1 returns 2 after 1 cycle.
